alu_issue_stage: RTL

// Issue/capture stage wrapped around the combinational ALU. Accepts one operation per

---
 rtl/alu_issue_if.sv | 26 ++
 rtl/alu_issue_stage.sv | 110 +++++++++++
 2 files changed

// File: rtl/alu_issue_if.sv
// Upstream request and downstream result handshakes of the ALU issue stage.
interface alu_issue_if #(
  parameter int unsigned L = 16,
  parameter int unsigned P = 0
);
  logic         InValid;
  logic         InReady;
  logic [P:0]   InOperation;
  logic [L-1:0] InB;
  logic [L-1:0] InC;
  logic [2:0]   InDest;
  logic         OutValid;
  logic         OutReady;
  logic [L-1:0] OutRes;
  logic [2:0]   OutDest;

  modport master (
    output InValid, InOperation, InB, InC, InDest, OutReady,
    input  InReady, OutValid, OutRes, OutDest
  );

  modport slave (
    input  InValid, InOperation, InB, InC, InDest, OutReady,
    output InReady, OutValid, OutRes, OutDest
  );
endinterface

// File: rtl/alu_issue_stage.sv
// Issue/capture stage around the combinational ALU: holds operands for SETTLE cycles,
// captures the result for writeback and owns the architectural flags register.
module alu_issue_stage #(
  parameter int unsigned L      = 16,
  parameter int unsigned P      = 0,
  parameter int unsigned SETTLE = 2
) (
  input  logic         Clk,
  input  logic         Reset_n,
  alu_issue_if.slave   bus,
  output logic [P:0]   AluOperation,
  output logic [L-1:0] AluB,
  output logic [L-1:0] AluC,
  output logic [L-1:0] AluFlagsIn,
  input  logic [L-1:0] AluRes,
  input  logic [L-1:0] AluFlagsOut,
  output logic [L-1:0] Flags,
  input  logic         FlagsClear
);

  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] COUNT_LOAD = CW'(SETTLE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [CW-1:0] count;
  logic          in_ready_c;
  logic          accept_c;
  logic          capture_c;
  logic          handoff_c;

  // State register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_n;
  end

  // Next state and handshake decode
  always_comb begin
    state_n    = state;
    in_ready_c = 1'b0;
    capture_c  = 1'b0;
    handoff_c  = 1'b0;
    case (state)
      IDLE: in_ready_c = 1'b1;
      EXEC: begin
        if (count == '0) begin
          capture_c = 1'b1;
          state_n   = DONE;
        end
      end
      DONE: begin
        if (bus.OutReady) begin
          in_ready_c = 1'b1;
          handoff_c  = 1'b1;
          state_n    = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    accept_c = bus.InValid & in_ready_c;
    if (accept_c) state_n = EXEC;
  end

  assign bus.InReady = in_ready_c;
  assign AluFlagsIn  = Flags;

  // Operand/tag latch, settle counter and result capture
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      AluOperation <= '0;
      AluB         <= '0;
      AluC         <= '0;
      bus.OutDest  <= '0;
      bus.OutRes   <= '0;
      bus.OutValid <= 1'b0;
      count        <= '0;
    end else begin
      if (accept_c) begin
        AluOperation <= bus.InOperation;
        AluB         <= bus.InB;
        AluC         <= bus.InC;
        bus.OutDest  <= bus.InDest;
        count        <= COUNT_LOAD;
      end else if (state == EXEC && count != '0) begin
        count <= count - CW'(1);
      end
      if (capture_c) begin
        bus.OutRes   <= AluRes;
        bus.OutValid <= 1'b1;
      end else if (handoff_c) begin
        bus.OutValid <= 1'b0;
      end
    end
  end

  // Flags register; a clear beats a coincident capture
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)       Flags <= '0;
    else if (FlagsClear) Flags <= '0;
    else if (capture_c)  Flags <= AluFlagsOut;
  end

endmodule
